// File: rtl/conv_accel_pkg.sv
// Shared controller state encoding and default widths for the convolution accelerator controller.
package conv_accel_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int LEN_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_e;

endpackage

// File: rtl/conv_accel_ctrl_if.sv
// Host job/data/result streams plus accelerator FIFO and status lines.
// slave = controller side, master = host/accelerator side.
interface conv_accel_ctrl_if
  import conv_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              job_valid;
  logic [LEN_W-1:0]  job_len;
  logic              job_ready;

  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready;

  logic [DATA_W-1:0] dataInput;
  logic              wr;
  logic              cStart;
  logic              cReady;
  logic              FULL;
  logic              EMPTY;
  logic [DATA_W-1:0] finalsum;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  logic              busy;
  logic              err_timeout;

  modport slave (
    input  job_valid, job_len, din_valid, din, cReady, FULL, EMPTY, finalsum, res_ready,
    output job_ready, din_ready, dataInput, wr, cStart, res_valid, res_data, busy, err_timeout
  );

  modport master (
    output job_valid, job_len, din_valid, din, cReady, FULL, EMPTY, finalsum, res_ready,
    input  job_ready, din_ready, dataInput, wr, cStart, res_valid, res_data, busy, err_timeout
  );

endinterface

// File: rtl/conv_ctrl_watchdog.sv
// WAIT-state watchdog: counts cycles while enabled, pulses expire on the TIMEOUT_CYC-th cycle.
module conv_ctrl_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_accel_ctrl.sv
// Job sequencer: streams job_len words into the accelerator FIFO (stalls on FULL), pulses cStart,
// waits for cReady, holds the result until res_ready. CONV_CTRL_TIMEOUT_EN adds a WAIT watchdog.
module conv_accel_ctrl
  import conv_accel_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              Clk,
  input logic              Rst,
  conv_accel_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_LOAD   = LOAD;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_WAIT   = WAIT;
  localparam logic [2:0] S_RESULT = RESULT;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] res_q;
  logic              err_q;
  logic              xfer;
  logic              accept;
  logic              expire;

  assign accept = (state == S_IDLE) && bus.job_valid && (bus.job_len != '0);
  assign xfer   = (state == S_LOAD) && bus.din_valid && !bus.FULL;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOAD;
      S_LOAD:   if (xfer && (remaining == LEN_W'(1))) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   if (bus.cReady || expire) state_nxt = S_RESULT;
      S_RESULT: if (bus.res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A real result wins over a watchdog expiry landing in the same cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      res_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        remaining <= bus.job_len;
      end else if (xfer) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (state == S_WAIT) begin
        if (bus.cReady) begin
          res_q <= bus.finalsum;
        end else if (expire) begin
          res_q <= '0;
        end
      end
    end
  end

`ifdef CONV_CTRL_TIMEOUT_EN
  conv_ctrl_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (state != S_WAIT),
    .en     (state == S_WAIT),
    .expire (expire)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if ((state == S_WAIT) && expire && !bus.cReady) begin
      err_q <= 1'b1;
    end
  end
`else
  wire [31:0] timeout_unused = 32'(TIMEOUT_CYC);
  assign expire = 1'b0;
  assign err_q  = 1'b0;
`endif

  // EMPTY is accelerator status only and never steers the sequencer.
  wire empty_unused = bus.EMPTY;

  assign bus.job_ready   = (state == S_IDLE) && !Rst;
  assign bus.din_ready   = (state == S_LOAD) && !bus.FULL;
  assign bus.wr          = xfer;
  assign bus.dataInput   = bus.din;
  assign bus.cStart      = (state == S_START);
  assign bus.res_valid   = (state == S_RESULT);
  assign bus.res_data    = res_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.err_timeout = err_q;

  a_no_wr_when_full: assert property (@(posedge Clk) disable iff (Rst) !(bus.wr && bus.FULL));
  a_cstart_one_cycle: assert property (@(posedge Clk) disable iff (Rst) bus.cStart |=> !bus.cStart);

endmodule

// File: tb/tb_conv_accel_ctrl.sv
// Directed bench for conv_accel_ctrl: load/stall/zero-length/hold/reset/timeout scenarios.
`timescale 1ns/1ps
module tb_conv_accel_ctrl;

  logic Clk = 1'b0;
  logic Rst;

  always #5 Clk = ~Clk;

  conv_accel_ctrl_if #(.DATA_W(16), .LEN_W(8)) bus ();

  conv_accel_ctrl #(
    .DATA_W(16),
    .LEN_W(8),
    .TIMEOUT_CYC(16)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int wr_cnt      = 0;
  int cs_cnt      = 0;
  int wr_full_cnt = 0;
  logic [15:0] wr_log [0:63];

  int lat;
  int base;
  int cs_base;
  int fb;

  // Mid-cycle monitor of FIFO writes and compute starts.
  always @(negedge Clk) begin
    if (bus.wr) begin
      wr_log[wr_cnt[5:0]] <= bus.dataInput;
      wr_cnt              <= wr_cnt + 1;
    end
    if (bus.cStart) cs_cnt <= cs_cnt + 1;
    if (bus.wr && bus.FULL) wr_full_cnt <= wr_full_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_res(input string tag, input int max);
    int n = 0;
    while (!bus.res_valid && n < max) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic finish_result();
    bus.res_ready = 1'b1;
    cyc();
    bus.res_ready = 1'b0;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    Rst           = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.cReady    = 1'b0;
    bus.FULL      = 1'b0;
    bus.EMPTY     = 1'b0;
    bus.finalsum  = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy",      32'(bus.busy),        0);
    chk("rst_wr",        32'(bus.wr),          0);
    chk("rst_cstart",    32'(bus.cStart),      0);
    chk("rst_din_ready", 32'(bus.din_ready),   0);
    chk("rst_res_valid", 32'(bus.res_valid),   0);
    chk("rst_res_data",  32'(bus.res_data),    0);
    chk("rst_err",       32'(bus.err_timeout), 0);
    Rst = 1'b0;
    #2;
    chk("rst_job_ready", 32'(bus.job_ready), 1);

    // Four back-to-back words, cReady three cycles after cStart.
    base = wr_cnt; cs_base = cs_cnt;
    bus.finalsum  = 16'h000A;
    bus.job_valid = 1'b1; bus.job_len = 8'd4;
    bus.din_valid = 1'b1; bus.din = 16'd1;
    cyc();
    bus.job_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.din = 16'(i);
      cyc();
    end
    bus.din_valid = 1'b0;
    chk("a_cstart", 32'(bus.cStart), 1);
    cyc(); cyc(); cyc();
    bus.cReady = 1'b1;
    wait_res("a_res_valid", 20);
    bus.cReady = 1'b0;
    chk("a_wr_count", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("a_word%0d", i + 1), 32'(wr_log[(base + i) % 64]), 32'(i + 1));
    chk("a_cstart_count", cs_cnt - cs_base, 1);
    chk("a_res_data", 32'(bus.res_data), 32'h000A);
    finish_result();
    chk("a_idle_busy", 32'(bus.busy), 0);
    chk("a_idle_job_ready", 32'(bus.job_ready), 1);

    // FULL stalls the stream for five cycles after the first word; EMPTY toggled as noise.
    base = wr_cnt; fb = wr_full_cnt;
    bus.EMPTY     = 1'b1;
    bus.finalsum  = 16'h0033;
    bus.job_valid = 1'b1; bus.job_len = 8'd3;
    bus.din_valid = 1'b1; bus.din = 16'h0011;
    cyc();
    bus.job_valid = 1'b0;
    cyc();
    bus.FULL = 1'b1; bus.din = 16'h0022;
    #2;
    chk("b_din_ready_full", 32'(bus.din_ready), 0);
    repeat (5) cyc();
    chk("b_wr_stalled", wr_cnt - base, 1);
    bus.FULL = 1'b0;
    cyc();
    bus.din = 16'h0033;
    cyc();
    bus.din_valid = 1'b0;
    chk("b_wr_count", wr_cnt - base, 3);
    chk("b_word1", 32'(wr_log[(base + 0) % 64]), 32'h11);
    chk("b_word2", 32'(wr_log[(base + 1) % 64]), 32'h22);
    chk("b_word3", 32'(wr_log[(base + 2) % 64]), 32'h33);
    chk("b_wr_while_full", wr_full_cnt - fb, 0);
    bus.cReady = 1'b1;
    wait_res("b_res_valid", 20);
    bus.cReady = 1'b0;
    chk("b_res_data", 32'(bus.res_data), 32'h0033);
    finish_result();
    bus.EMPTY = 1'b0;

    // Zero-length job is ignored.
    base = wr_cnt; cs_base = cs_cnt;
    bus.job_valid = 1'b1; bus.job_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("c_job_ready", 32'(bus.job_ready), 1);
      chk("c_busy", 32'(bus.busy), 0);
    end
    bus.job_valid = 1'b0;
    chk("c_no_wr", wr_cnt - base, 0);
    chk("c_no_cstart", cs_cnt - cs_base, 0);

    // cReady already high: minimum latency, then a long res_ready stall.
    bus.finalsum  = 16'h1234;
    bus.cReady    = 1'b1;
    bus.job_valid = 1'b1; bus.job_len = 8'd2;
    bus.din_valid = 1'b1; bus.din = 16'h0005;
    cyc();
    bus.job_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      cyc();
      lat++;
    end
    chk("d_latency", lat, 4);
    bus.cReady    = 1'b0;
    bus.din_valid = 1'b0;
    bus.finalsum  = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("d_hold_valid", 32'(bus.res_valid), 1);
      chk("d_hold_data", 32'(bus.res_data), 32'h1234);
      chk("d_hold_job_ready", 32'(bus.job_ready), 0);
    end
    finish_result();
    chk("d_released", 32'(bus.res_valid), 0);

    // Reset after the second word of a five-word job, then a clean two-word job.
    base = wr_cnt; cs_base = cs_cnt;
    bus.finalsum  = 16'h0055;
    bus.job_valid = 1'b1; bus.job_len = 8'd5;
    bus.din_valid = 1'b1; bus.din = 16'h0040;
    cyc();
    bus.job_valid = 1'b0;
    cyc(); cyc();
    Rst = 1'b1;
    #1;
    chk("e_rst_busy",      32'(bus.busy),        0);
    chk("e_rst_wr",        32'(bus.wr),          0);
    chk("e_rst_din_ready", 32'(bus.din_ready),   0);
    chk("e_rst_cstart",    32'(bus.cStart),      0);
    chk("e_rst_res_valid", 32'(bus.res_valid),   0);
    chk("e_rst_res_data",  32'(bus.res_data),    0);
    chk("e_rst_err",       32'(bus.err_timeout), 0);
    cyc();
    Rst = 1'b0;
    #2;
    chk("e_job_ready", 32'(bus.job_ready), 1);
    repeat (3) cyc();
    chk("e_wr_discarded", wr_cnt - base, 2);
    chk("e_no_cstart", cs_cnt - cs_base, 0);
    bus.job_valid = 1'b1; bus.job_len = 8'd2; bus.din = 16'h0066;
    cyc();
    bus.job_valid = 1'b0;
    cyc();
    bus.din = 16'h0077;
    cyc();
    bus.din_valid = 1'b0;
    bus.cReady    = 1'b1;
    wait_res("e_res_valid", 20);
    bus.cReady = 1'b0;
    chk("e_wr_count", wr_cnt - base, 4);
    chk("e_word1", 32'(wr_log[(base + 2) % 64]), 32'h66);
    chk("e_word2", 32'(wr_log[(base + 3) % 64]), 32'h77);
    chk("e_cstart_count", cs_cnt - cs_base, 1);
    chk("e_res_data", 32'(bus.res_data), 32'h0055);
    finish_result();

`ifdef CONV_CTRL_TIMEOUT_EN
    // cReady never arrives: watchdog fires after 16 WAIT cycles.
    bus.finalsum  = 16'hBEEF;
    bus.job_valid = 1'b1; bus.job_len = 8'd1;
    bus.din_valid = 1'b1; bus.din = 16'h0009;
    cyc();
    bus.job_valid = 1'b0;
    cyc();
    bus.din_valid = 1'b0;
    chk("f_cstart", 32'(bus.cStart), 1);
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      chk("f_err_early", 32'(bus.err_timeout), 0);
      cyc();
      lat++;
    end
    chk("f_wait_cycles", lat, 17);
    chk("f_err", 32'(bus.err_timeout), 1);
    chk("f_res_data", 32'(bus.res_data), 0);
    finish_result();
    chk("f_err_sticky", 32'(bus.err_timeout), 1);
    chk("f_idle", 32'(bus.busy), 0);
`else
    chk("f_err_tied", 32'(bus.err_timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_accel_ctrl.md
CONV_ACCEL_CTRL -- requirements
Module: conv_accel_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width of the accelerator data/result path.
REQ-002 SHALL have parameter LEN_W, default 8, width of the job length field.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in Clk cycles.
REQ-004 SHALL have port Clk  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port Rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port job_valid  in  1  host requests a job.
REQ-007 SHALL have port job_len  in  LEN_W  number of words to load, 1..2^LEN_W-1.
REQ-008 SHALL have port job_ready  out  1  controller accepts a job.
REQ-009 SHALL have port din_valid / din / din_ready  in 1 / in DATA_W / out 1  host data stream.
REQ-010 SHALL have port dataInput  out  DATA_W  word to the accelerator FIFO.
REQ-011 SHALL have port wr  out  1  FIFO write strobe, synchronous to Clk (integrator ties wr_clk to Clk).
REQ-012 SHALL have port cStart  out  1  single-cycle compute start pulse.
REQ-013 SHALL have ports cReady, FULL, EMPTY  in  1 each  accelerator status.
REQ-014 SHALL have port finalsum  in  DATA_W  accelerator result.
REQ-015 SHALL have ports res_valid / res_data / res_ready  out 1 / out DATA_W / in 1  result stream.
REQ-016 SHALL have ports busy  out 1 (state != IDLE) and err_timeout  out 1  sticky watchdog flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, START, WAIT, RESULT.
REQ-018 IDLE: job_ready=1; job_valid&&job_len!=0 -> latch job_len into remaining count, go LOAD; job_len==0 is ignored (job_ready stays 1, no transition).
REQ-019 LOAD: din_ready = !FULL; a word transfers when din_valid&&din_ready; on transfer, in the same cycle wr=1 and dataInput=din (combinational path), and remaining decrements.
REQ-020 LOAD: transfer of the last word (remaining==1) -> START next cycle; FULL=1 stalls without loss; no wr while FULL.
REQ-021 START: cStart=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: on cReady=1 capture finalsum into res_data register, go RESULT; cReady already high on WAIT entry is accepted on the first WAIT cycle.
REQ-023 RESULT: res_valid=1, res_data stable until res_valid&&res_ready; then IDLE; res_ready low holds indefinitely.
REQ-024 Minimum job latency, job accept to res_valid: job_len + 2 + (cycles until cReady) cycles with din_valid continuously high and FULL low.
REQ-025 wr, cStart, din_ready, job_ready SHALL be 0 in every state other than those granting them.
REQ-026 EMPTY is status only; it SHALL not alter FSM flow.

Reset
REQ-027 Rst asserted at any time SHALL asynchronously force IDLE, remaining=0, res_data=0, res_valid=0, wr=0, cStart=0, din_ready=0, err_timeout=0, busy=0; job_ready=1 after release.
REQ-028 Reset mid-LOAD or mid-WAIT SHALL discard the job with no further wr or cStart.

Configuration
REQ-029 Macro CONV_CTRL_TIMEOUT_EN SHALL, when defined, enable a WAIT-state watchdog: after TIMEOUT_CYC cycles in WAIT without cReady, set err_timeout=1 (sticky until Rst), load res_data=0, go RESULT.
REQ-030 Without CONV_CTRL_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_timeout SHALL be tied 0.

Structure
REQ-031 Shared package conv_accel_pkg SHALL hold the state enum typedef and default DATA_W/LEN_W constants.
REQ-032 Watchdog counter SHALL be sub-module conv_ctrl_watchdog (clear on WAIT entry, count in WAIT, expire pulse), instantiated only under CONV_CTRL_TIMEOUT_EN.

Verification
REQ-033 job_len=4, din 1,2,3,4 back-to-back, cReady 3 cycles after cStart, finalsum=0x000A -> four wr with dataInput 1..4, one cStart, res_data=0x000A.
REQ-034 job_len=3, FULL high for 5 cycles after word 1 -> no wr while FULL, words 2,3 written after, exactly 3 wr total.
REQ-035 job_len=0 with job_valid=1 -> stays IDLE, no wr, no cStart.
REQ-036 res_ready low 10 cycles in RESULT -> res_valid held, res_data unchanged, job_ready=0.
REQ-037 Rst pulse after word 2 of job_len=5 -> immediate IDLE, outputs at reset values, subsequent job_len=2 completes normally.
REQ-038 With CONV_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16, cReady never asserted -> err_timeout=1 on the 16th WAIT cycle, res_valid=1 with res_data=0.
